spi_tx_arbiter: RTL and testbench

- Shares the single 9-bit SPI transmit serializer between N packet sources (e.g. per-band peak extractors).
- Grants one source per packet with round-robin fairness and prefixes each packet with a header word that identifies the source.
- Presents words to the serializer through its FIFO-style interface: data, empty and a pop pulse.
- Aborts a packet if the granted source stalls mid-packet.

---
 rtl/spi_tx_arbiter.sv | 122 ++++++++++++
 tb/tb_spi_tx_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_arbiter.sv
// rtl/spi_tx_arbiter.sv - round-robin packet arbiter feeding a 9-bit SPI transmit FIFO-style port
// Adds a source-id header word per packet and emits an abort word when the granted source stalls.
module spi_tx_arbiter #(
    parameter int         N          = 4,
    parameter int         STALL_MAX  = 64,
    parameter logic [8:0] ABORT_WORD = 9'h1FF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic [8:0]     out_data,
    output logic           out_empty,
    input  logic           out_pop,
    output logic           busy,
    output logic [7:0]     abort_cnt
);

    localparam int SW = $clog2(STALL_MAX);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, ABORT} state_t;

    state_t        state;
    logic [3:0]    grant;
    logic [3:0]    rr_ptr;
    logic [SW-1:0] stall_cnt;

    logic          load_ok;
    logic [N-1:0]  gmask;
    logic [7:0]    sel_byte;
    logic          sel_valid;
    logic          sel_last;
    logic          accept;
    logic [3:0]    next_ptr;
    logic [N-1:0]  rot;
    logic          found;
    logic [4:0]    off;
    logic [4:0]    sum;
    logic [3:0]    pick;

    // A pop frees the holding register in the same cycle, so a new word may replace it.
    assign load_ok   = out_empty | out_pop;
    assign gmask     = {{(N-1){1'b0}}, 1'b1} << grant;
    assign sel_byte  = 8'(req_data >> {grant, 3'b000});
    assign sel_valid = |(req_valid & gmask);
    assign sel_last  = |(req_last & gmask);
    assign accept    = (state == PAYLOAD) && sel_valid && load_ok;
    assign req_ready = accept ? gmask : '0;
    assign next_ptr  = (grant == 4'(N - 1)) ? 4'd0 : grant + 4'd1;
    assign busy      = (state != IDLE);

    // Rotate requests so bit 0 is rr_ptr; the lowest set bit is the next grant.
    always_comb begin
        rot   = N'({req_valid, req_valid} >> rr_ptr);
        found = |rot;
        off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = 5'(k);
        end
        sum  = {1'b0, rr_ptr} + off;
        pick = (sum >= 5'(N)) ? 4'(sum - 5'(N)) : sum[3:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            stall_cnt <= '0;
            out_data  <= '0;
            out_empty <= 1'b1;
            abort_cnt <= '0;
        end else begin
            if (out_pop) out_empty <= 1'b1;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= pick;
                        state <= HEADER;
                    end
                end
                HEADER: begin
                    if (load_ok) begin
                        out_data  <= {5'b10000, grant};
                        out_empty <= 1'b0;
                        stall_cnt <= '0;
                        state     <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        out_data  <= {1'b0, sel_byte};
                        out_empty <= 1'b0;
                        stall_cnt <= '0;
                        if (sel_last) begin
                            rr_ptr <= next_ptr;
                            state  <= IDLE;
                        end
                    end else if (!sel_valid) begin
                        // Only a silent source counts as a stall; sink backpressure does not.
                        if (stall_cnt == STALL_LAST) state <= ABORT;
                        else stall_cnt <= stall_cnt + SW'(1);
                    end
                end
                ABORT: begin
                    if (load_ok) begin
                        out_data  <= ABORT_WORD;
                        out_empty <= 1'b0;
                        if (abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
                        rr_ptr    <= next_ptr;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb/tb_spi_tx_arbiter.sv - self-checking bench for spi_tx_arbiter
// Sources are packet queues; expected output streams come from a queue-level round-robin model.
module tb_spi_tx_arbiter;

    localparam int N         = 4;
    localparam int STALL_MAX = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [8:0]     out_data;
    logic           out_empty;
    logic           out_pop;
    logic           busy;
    logic [7:0]     abort_cnt;

    spi_tx_arbiter #(.N(N), .STALL_MAX(STALL_MAX), .ABORT_WORD(9'h1FF)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .out_data(out_data),
        .out_empty(out_empty), .out_pop(out_pop), .busy(busy), .abort_cnt(abort_cnt)
    );

    always #5 clk = ~clk;

    // Each entry is {last, byte}; a final entry without last models a source that goes silent.
    logic [8:0] srcq[N][$];
    logic [8:0] got[$];
    int         got_cyc[$];
    logic [8:0] exp_q[$];
    int         mptr;
    int         cyc;
    int         pop_pct;
    int         checks;
    int         failures;

    task automatic drive_sources();
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                req_valid[i]        = 1'b1;
                req_data[8*i +: 8]  = srcq[i][0][7:0];
                req_last[i]         = srcq[i][0][8];
            end else begin
                req_valid[i]        = 1'b0;
                req_last[i]         = 1'b0;
                req_data[8*i +: 8]  = 8'($urandom);
            end
        end
    endtask

    // One clock cycle: choose out_pop, record the popped word, advance accepted sources.
    task automatic step();
        logic [N-1:0] rr;
        out_pop = ($urandom_range(0, 99) < pop_pct);
        #1;
        rr = req_ready;
        checks++;
        if ((rr != '0 && !(out_empty || out_pop)) || $countones(rr) > 1 || (rr & ~req_valid) != '0) begin
            failures++;
            $display("FAIL req_ready_legal: req_ready=%b out_empty=%b out_pop=%b req_valid=%b",
                     rr, out_empty, out_pop, req_valid);
        end
        if (out_pop && !out_empty) begin
            got.push_back(out_data);
            got_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (rr[i]) void'(srcq[i].pop_front());
        end
        drive_sources();
    endtask

    function automatic bit done();
        bit e = 1'b1;
        for (int i = 0; i < N; i++) if (srcq[i].size() != 0) e = 1'b0;
        return e && !busy && out_empty;
    endfunction

    task automatic run_until_done(input int max, output bit timeout);
        int c = 0;
        drive_sources();
        while (!done() && c < max) begin
            step();
            c++;
        end
        timeout = !done();
    endtask

    // Reference: grant the first non-empty queue from mptr, emit header, bytes up to last,
    // or an abort word if the queue runs dry before last; the pointer then moves past the winner.
    task automatic build_expected();
        logic [8:0] q[N][$];
        logic [8:0] w;
        int         s;
        bit         any;
        for (int i = 0; i < N; i++) q[i] = srcq[i];
        exp_q.delete();
        forever begin
            any = 1'b0;
            s   = 0;
            for (int k = 0; k < N; k++) begin
                if (!any && q[(mptr + k) % N].size() > 0) begin
                    any = 1'b1;
                    s   = (mptr + k) % N;
                end
            end
            if (!any) break;
            exp_q.push_back({5'b10000, 4'(s)});
            forever begin
                if (q[s].size() == 0) begin
                    exp_q.push_back(9'h1FF);
                    break;
                end
                w = q[s].pop_front();
                exp_q.push_back({1'b0, w[7:0]});
                if (w[8]) break;
            end
            mptr = (s + 1) % N;
        end
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_pop   = 1'b0;
        for (int i = 0; i < N; i++) srcq[i].delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mptr  = 0;
        got.delete();
        got_cyc.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (out_empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b want 1", out_empty); end
        checks++;
        if (out_data !== 9'h000) begin failures++; $display("FAIL reset_data: got %h want 000", out_data); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (req_ready !== '0) begin failures++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        checks++;
        if (abort_cnt !== 8'd0) begin failures++; $display("FAIL reset_abort_cnt: got %0d want 0", abort_cnt); end
    endtask

    task automatic test_single_packet();
        bit to;
        int start;
        apply_reset();
        pop_pct = 100;
        srcq[1].push_back(9'h012);
        srcq[1].push_back(9'h134);
        build_expected();
        start = cyc;
        run_until_done(200, to);
        checks++;
        if (to) begin failures++; $display("FAIL single_timeout: DUT not idle within 200 cycles"); end
        checks++;
        if (got.size() != exp_q.size()) begin failures++; $display("FAIL single_count: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL single_word[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 9'hxxx, exp_q[i]);
            end
        end
        checks++;
        if (got_cyc.size() == 0 || got_cyc[0] - start != 2) begin
            failures++;
            $display("FAIL header_latency: got %0d want 2", (got_cyc.size() > 0) ? got_cyc[0] - start : -1);
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL single_busy: got %b want 0", busy); end
        // Pointer should now sit at source 2, so 2 beats 0.
        got.delete();
        got_cyc.delete();
        srcq[0].push_back(9'h1AA);
        srcq[2].push_back(9'h1BB);
        build_expected();
        run_until_done(200, to);
        checks++;
        if (to) begin failures++; $display("FAIL rrptr_timeout: DUT not idle within 200 cycles"); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rrptr_word[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 9'hxxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        bit to;
        apply_reset();
        pop_pct = 100;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++) srcq[i].push_back({1'b1, 8'($urandom)});
        build_expected();
        run_until_done(400, to);
        checks++;
        if (to) begin failures++; $display("FAIL rr_timeout: DUT not idle within 400 cycles"); end
        checks++;
        if (got.size() != exp_q.size()) begin failures++; $display("FAIL rr_count: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rr_word[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 9'hxxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        apply_reset();
        for (int i = 0; i < 3; i++) srcq[0].push_back({(i == 2), 8'($urandom)});
        build_expected();
        drive_sources();
        pop_pct = 0;
        repeat (20) step();
        checks++;
        if (out_empty !== 1'b0 || out_data !== 9'h100) begin
            failures++;
            $display("FAIL bp_hold: got empty=%b data=%h want empty=0 data=100", out_empty, out_data);
        end
        checks++;
        if (busy !== 1'b1 || abort_cnt !== 8'd0) begin
            failures++;
            $display("FAIL bp_no_stall: got busy=%b abort_cnt=%0d want busy=1 abort_cnt=0", busy, abort_cnt);
        end
        pop_pct = 100;
        run_until_done(200, to);
        checks++;
        if (to) begin failures++; $display("FAIL bp_timeout: DUT not idle within 200 cycles"); end
        checks++;
        if (got.size() != exp_q.size()) begin failures++; $display("FAIL bp_count: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL bp_word[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 9'hxxx, exp_q[i]);
            end
        end
        checks++;
        if (abort_cnt !== 8'd0) begin failures++; $display("FAIL bp_abort_cnt: got %0d want 0", abort_cnt); end
    endtask

    task automatic test_stall_abort();
        bit to;
        apply_reset();
        pop_pct = 100;
        srcq[2].push_back({1'b0, 8'($urandom)});
        srcq[3].push_back({1'b1, 8'($urandom)});
        build_expected();
        run_until_done(300, to);
        checks++;
        if (to) begin failures++; $display("FAIL abort_timeout: DUT not idle within 300 cycles"); end
        checks++;
        if (got.size() != exp_q.size()) begin failures++; $display("FAIL abort_count: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL abort_word[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 9'hxxx, exp_q[i]);
            end
        end
        // STALL_MAX silent cycles, then one ABORT cycle to load the abort word.
        checks++;
        if (got_cyc.size() < 3 || got_cyc[2] - got_cyc[1] != STALL_MAX + 1) begin
            failures++;
            $display("FAIL abort_timing: got %0d want %0d", (got_cyc.size() >= 3) ? got_cyc[2] - got_cyc[1] : -1, STALL_MAX + 1);
        end
        checks++;
        if (abort_cnt !== 8'd1) begin failures++; $display("FAIL abort_cnt: got %0d want 1", abort_cnt); end
    endtask

    task automatic test_reset_mid_packet();
        bit to;
        apply_reset();
        pop_pct = 100;
        srcq[1].push_back(9'h155);
        run_until_done(200, to);
        got.delete();
        got_cyc.delete();
        for (int i = 0; i < 4; i++) srcq[0].push_back({(i == 3), 8'($urandom)});
        drive_sources();
        repeat (4) step();
        pop_pct = 0;
        repeat (3) step();
        checks++;
        if (busy !== 1'b1 || out_empty !== 1'b0) begin
            failures++;
            $display("FAIL mid_pre: got busy=%b empty=%b want busy=1 empty=0", busy, out_empty);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (out_empty !== 1'b1 || out_data !== 9'h000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got empty=%b data=%h busy=%b want empty=1 data=000 busy=0", out_empty, out_data, busy);
        end
        for (int i = 0; i < N; i++) srcq[i].delete();
        mptr = 0;
        got.delete();
        got_cyc.delete();
        pop_pct = 100;
        srcq[0].push_back(9'h011);
        srcq[0].push_back(9'h122);
        srcq[3].push_back(9'h133);
        build_expected();
        run_until_done(300, to);
        checks++;
        if (to) begin failures++; $display("FAIL mid_timeout: DUT not idle within 300 cycles"); end
        checks++;
        if (got.size() == 0 || got[0] !== 9'h100) begin
            failures++;
            $display("FAIL mid_first_header: got %h want 100", (got.size() > 0) ? got[0] : 9'hxxx);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL mid_word[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 9'hxxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_ff_payload();
        bit to;
        apply_reset();
        pop_pct = 100;
        srcq[3].push_back(9'h1FF);
        build_expected();
        run_until_done(200, to);
        checks++;
        if (to) begin failures++; $display("FAIL ff_timeout: DUT not idle within 200 cycles"); end
        checks++;
        if (got.size() != exp_q.size()) begin failures++; $display("FAIL ff_count: got %0d want %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL ff_word[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 9'hxxx, exp_q[i]);
            end
        end
        checks++;
        if (abort_cnt !== 8'd0) begin failures++; $display("FAIL ff_abort_cnt: got %0d want 0", abort_cnt); end
    endtask

    task automatic test_random();
        bit to;
        int len;
        apply_reset();
        for (int r = 0; r < 4; r++) begin
            got.delete();
            got_cyc.delete();
            pop_pct = $urandom_range(30, 100);
            for (int i = 0; i < N; i++)
                for (int p = $urandom_range(0, 2); p > 0; p--) begin
                    len = $urandom_range(1, 4);
                    for (int w = 0; w < len; w++) srcq[i].push_back({(w == len - 1), 8'($urandom)});
                end
            build_expected();
            run_until_done(3000, to);
            checks++;
            if (to) begin failures++; $display("FAIL rand_timeout[%0d]: DUT not idle within 3000 cycles", r); end
            checks++;
            if (got.size() != exp_q.size()) begin failures++; $display("FAIL rand_count[%0d]: got %0d want %0d", r, got.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (i >= got.size() || got[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL rand_word[%0d][%0d]: got %h want %h", r, i, (i < got.size()) ? got[i] : 9'hxxx, exp_q[i]);
                end
            end
        end
        checks++;
        if (abort_cnt !== 8'd0) begin failures++; $display("FAIL rand_abort_cnt: got %0d want 0", abort_cnt); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        pop_pct  = 100;
        mptr     = 0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_stall_abort();
        test_reset_mid_packet();
        test_ff_payload();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
